// File: rtl/rx_dcoffset_ctrl.sv
// Burst-aware clear/settle sequencer and settings-bus arbiter for the I/Q DC-offset correctors.
// Host writes are forwarded one cycle late; sequencer clears use the bus only when no forward is pending.
module rx_dcoffset_ctrl #(
  parameter logic [7:0] ADDR_CTRL = 8'd0,
  parameter logic [7:0] ADDR_I    = 8'd1,
  parameter logic [7:0] ADDR_Q    = 8'd2,
  parameter int         CNT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic        burst_start,
  input  logic        sample_stb,
  output logic        out_set_stb,
  output logic [7:0]  out_set_addr,
  output logic [31:0] out_set_data,
  output logic        busy,
  output logic        settled
);

  typedef enum logic [1:0] {IDLE, WR_I, WR_Q, SETTLE} state_t;

  localparam logic [31:0]          CLR_WORD = {2'b01, 30'b0};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  state_t                 state_reg, state_next;
  logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next, cnt_inc;
  logic                   settled_reg, settled_next;
  logic                   auto_clr_en_reg;
  logic [CNT_WIDTH-1:0]   settle_len_reg;
  logic                   shadow_i_reg, shadow_q_reg;
  logic                   fwd_stb_reg;
  logic [7:0]             fwd_addr_reg;
  logic [31:0]            fwd_data_reg;

  logic                   host_fwd;
  logic                   fixed_i, fixed_q;
  logic                   seq_stb;
  logic [7:0]             seq_addr;

  assign host_fwd = set_stb && (set_addr != ADDR_CTRL);

  // Skip decisions see a host mode write landing in the same cycle.
  assign fixed_i = (set_stb && set_addr == ADDR_I) ? set_data[31] : shadow_i_reg;
  assign fixed_q = (set_stb && set_addr == ADDR_Q) ? set_data[31] : shadow_q_reg;

  assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    settled_next = settled_reg;
    seq_stb      = 1'b0;
    seq_addr     = ADDR_I;
    case (state_reg)
      IDLE: begin
        if (burst_start && auto_clr_en_reg) begin
          state_next   = WR_I;
          cnt_next     = '0;
          settled_next = 1'b0;
        end
      end
      WR_I: begin
        if (fixed_i) begin
          state_next = WR_Q;
        end else if (!fwd_stb_reg) begin
          seq_stb    = 1'b1;
          seq_addr   = ADDR_I;
          state_next = WR_Q;
        end
      end
      WR_Q: begin
        if (fixed_q) begin
          state_next = SETTLE;
        end else if (!fwd_stb_reg) begin
          seq_stb    = 1'b1;
          seq_addr   = ADDR_Q;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (sample_stb) begin
          cnt_next = cnt_inc;
        end
        // Exit on the cycle the final sample arrives so settled rises one cycle later.
        if ((cnt_reg == settle_len_reg) || (sample_stb && cnt_inc == settle_len_reg)) begin
          state_next   = IDLE;
          settled_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (state_reg != IDLE && burst_start) begin
      state_next   = WR_I;
      cnt_next     = '0;
      settled_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      settled_reg     <= 1'b0;
      auto_clr_en_reg <= 1'b0;
      settle_len_reg  <= '0;
      shadow_i_reg    <= 1'b0;
      shadow_q_reg    <= 1'b0;
      fwd_stb_reg     <= 1'b0;
      fwd_addr_reg    <= '0;
      fwd_data_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      settled_reg  <= settled_next;
      fwd_stb_reg  <= host_fwd;
      fwd_addr_reg <= set_addr;
      fwd_data_reg <= set_data;
      if (set_stb && set_addr == ADDR_CTRL) begin
        auto_clr_en_reg <= set_data[31];
        settle_len_reg  <= set_data[CNT_WIDTH-1:0];
      end
      if (set_stb && set_addr == ADDR_I) shadow_i_reg <= set_data[31];
      if (set_stb && set_addr == ADDR_Q) shadow_q_reg <= set_data[31];
    end
  end

  // Output bus: pending host forward has priority; nothing is driven while reset is held.
  always_comb begin
    out_set_stb  = 1'b0;
    out_set_addr = '0;
    out_set_data = '0;
    if (!rst) begin
      if (fwd_stb_reg) begin
        out_set_stb  = 1'b1;
        out_set_addr = fwd_addr_reg;
        out_set_data = fwd_data_reg;
      end else if (seq_stb) begin
        out_set_stb  = 1'b1;
        out_set_addr = seq_addr;
        out_set_data = CLR_WORD;
      end
    end
  end

  assign busy    = (state_reg != IDLE);
  assign settled = settled_reg;

endmodule

// File: tb/tb_rx_dcoffset_ctrl.sv
// Directed bench for rx_dcoffset_ctrl: expected bus writes are queued with their cycle and
// checked every cycle by a monitor; status outputs are checked inline.
module tb_rx_dcoffset_ctrl;

  localparam logic [7:0]  A_CTRL = 8'd0;
  localparam logic [7:0]  A_I    = 8'd1;
  localparam logic [7:0]  A_Q    = 8'd2;
  localparam logic [31:0] CLR    = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic        burst_start;
  logic        sample_stb;
  logic        out_set_stb;
  logic [7:0]  out_set_addr;
  logic [31:0] out_set_data;
  logic        busy;
  logic        settled;

  typedef struct {
    int          cyc;
    logic [7:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rx_dcoffset_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .set_stb     (set_stb),
    .set_addr    (set_addr),
    .set_data    (set_data),
    .burst_start (burst_start),
    .sample_stb  (sample_stb),
    .out_set_stb (out_set_stb),
    .out_set_addr(out_set_addr),
    .out_set_data(out_set_data),
    .busy        (busy),
    .settled     (settled)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want)
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: observed=%h expected=%h", tag, cyc, got, want);
    end
  endtask

  // Bus monitor: every cycle the strobe must match the scoreboard exactly.
  always @(negedge clk) begin : mon
    logic exp_stb;
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
    exp_stb = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    chk("out_set_stb", {31'b0, out_set_stb}, {31'b0, exp_stb});
    if (exp_stb) begin
      e = exp_q.pop_front();
      chk("out_set_addr", {24'b0, out_set_addr}, {24'b0, e.a});
      chk("out_set_data", out_set_data, e.d);
      if (out_set_stb) $display("cyc=%0d write addr=%h data=%h", cyc, out_set_addr, out_set_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [7:0] a, input logic [31:0] d);
    set_stb  = 1'b1;
    set_addr = a;
    set_data = d;
    if (a != A_CTRL) exp_q.push_back('{cyc + 1, a, d});
    tick();
    set_stb  = 1'b0;
    set_addr = '0;
    set_data = '0;
  endtask

  // Burst on an idle bus; returns in the first SETTLE cycle.
  task automatic do_burst(input bit exp_i, input bit exp_q_wr);
    int b;
    b = cyc;
    burst_start = 1'b1;
    if (exp_i)    exp_q.push_back('{b + 1, A_I, CLR});
    if (exp_q_wr) exp_q.push_back('{b + 2, A_Q, CLR});
    tick();
    burst_start = 1'b0;
    chk("busy_after_burst", {31'b0, busy}, 32'd1);
    chk("settled_after_burst", {31'b0, settled}, 32'd0);
    tick();
    tick();
  endtask

  task automatic samples(input int n, input bit expect_done);
    for (int i = 0; i < n; i++) begin
      chk("settled_during", {31'b0, settled}, 32'd0);
      chk("busy_during", {31'b0, busy}, 32'd1);
      sample_stb = 1'b1;
      tick();
      sample_stb = 1'b0;
    end
    if (expect_done) begin
      chk("settled_done", {31'b0, settled}, 32'd1);
      chk("busy_done", {31'b0, busy}, 32'd0);
    end
  endtask

  initial begin
    int b;
    rst = 1'b1; set_stb = 1'b0; set_addr = '0; set_data = '0;
    burst_start = 1'b0; sample_stb = 1'b0;
    repeat (3) tick();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_settled", {31'b0, settled}, 32'd0);
    chk("rst_out_addr", {24'b0, out_set_addr}, 32'd0);
    chk("rst_out_data", out_set_data, 32'd0);
    rst = 1'b0;
    tick();

    // 1: basic clear/settle with settle_len = 4
    host_wr(A_CTRL, 32'h8000_0004);
    do_burst(1, 1);
    samples(4, 1);
    repeat (3) tick();

    // 2: Q in fixed mode is skipped
    host_wr(A_Q, 32'h8000_1234);
    do_burst(1, 0);
    samples(4, 1);
    host_wr(A_Q, 32'h0000_0000);
    tick();

    // 3: host holds the bus for three cycles starting with burst_start
    b = cyc;
    burst_start = 1'b1;
    set_stb = 1'b1; set_addr = A_I; set_data = 32'h0000_0000;
    for (int i = 1; i <= 3; i++) exp_q.push_back('{b + i, A_I, 32'h0000_0000});
    exp_q.push_back('{b + 4, A_I, CLR});
    exp_q.push_back('{b + 5, A_Q, CLR});
    tick();
    burst_start = 1'b0;
    tick();
    tick();
    set_stb = 1'b0; set_addr = '0;
    chk("busy_stalled", {31'b0, busy}, 32'd1);
    repeat (3) tick();
    samples(4, 1);

    // 4: restart during SETTLE after 2 samples
    do_burst(1, 1);
    samples(2, 0);
    do_burst(1, 1);
    samples(4, 1);

    // 5a: settle_len = 0 settles at cycle 4 with no samples
    host_wr(A_CTRL, 32'h8000_0000);
    do_burst(1, 1);
    chk("len0_settled_c3", {31'b0, settled}, 32'd0);
    tick();
    chk("len0_settled_c4", {31'b0, settled}, 32'd1);
    chk("len0_busy_c4", {31'b0, busy}, 32'd0);

    // 5b: auto_clr_en = 0 ignores burst_start
    host_wr(A_CTRL, 32'h0000_0004);
    burst_start = 1'b1;
    tick();
    burst_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("noauto_busy", {31'b0, busy}, 32'd0);
      chk("noauto_settled", {31'b0, settled}, 32'd1);
      tick();
    end

    // 6: reset while in WR_Q, then a control write that must not be forwarded
    host_wr(A_CTRL, 32'h8000_0004);
    b = cyc;
    burst_start = 1'b1;
    exp_q.push_back('{b + 1, A_I, CLR});
    tick();
    burst_start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_settled", {31'b0, settled}, 32'd0);
    chk("rst_mid_stb", {31'b0, out_set_stb}, 32'd0);
    host_wr(A_CTRL, 32'h8000_0008);
    repeat (3) tick();
    chk("ctrl_not_fwd_busy", {31'b0, busy}, 32'd0);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
